sram_req_responder: RTL and testbench

//   Responder end of the rd/wr req-ack-vld SRAM request protocol used by the shift and

---
 rtl/sram_req_responder_pkg.sv | 22 ++
 rtl/sram_rd_pipe.sv | 37 +++
 rtl/sram_req_responder.sv | 168 ++++++++++++++++
 tb/tb_sram_req_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_req_responder_pkg.sv
// Shared definitions for the SRAM request responder: FSM encodings and a
// width helper used to size the turnaround counter.
package sram_req_responder_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_TURN  = 2'd3;

   // Smallest bit count able to hold max_val (never less than one bit).
   function automatic int cnt_width(input int max_val);
      int w;
      w = 32'sd1;
      for (int i = 1; i < 31; i++) begin
         if ((32'sd1 << i) <= max_val) begin
            w = i + 32'sd1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return pipeline: tracks issued reads for READ_LATENCY cycles, then
// captures the SRAM data and flags it valid for one cycle.
module sram_rd_pipe #(
   parameter int READ_LATENCY    = 3,
   parameter int SRAM_DATA_WIDTH = 72
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       issue_rd,
   input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data,
   output logic                       rd_vld,
   output logic [SRAM_DATA_WIDTH-1:0] rd_data
);

   // Top bit of the shift register is the registered rd_vld itself.
   logic [READ_LATENCY:0]        vld_sr_r;
   logic [SRAM_DATA_WIDTH-1:0]   rd_data_r;

   // Valid shift register and data capture; reset drops everything in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_sr_r  <= '0;
         rd_data_r <= '0;
      end else begin
         vld_sr_r <= {vld_sr_r[READ_LATENCY-1:0], issue_rd};
         if (vld_sr_r[READ_LATENCY-1]) begin
            rd_data_r <= sram_rd_data;
         end else begin
            rd_data_r <= rd_data_r;
         end
      end
   end

   assign rd_vld  = vld_sr_r[READ_LATENCY];
   assign rd_data = rd_data_r;

endmodule

// File: rtl/sram_req_responder.sv
// Responder side of the rd/wr req-ack-vld protocol: holds one pending read and
// one pending write and arbitrates them onto a single-port pipelined SRAM.
module sram_req_responder #(
   parameter int SRAM_ADDR_WIDTH = 19,
   parameter int SRAM_DATA_WIDTH = 72,
   parameter int READ_LATENCY    = 3,
   parameter int TURNAROUND      = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       rd_req,
   input  logic [SRAM_ADDR_WIDTH-1:0] rd_addr,
   output logic                       rd_ack,
   output logic                       rd_vld,
   output logic [SRAM_DATA_WIDTH-1:0] rd_data,
   input  logic                       wr_req,
   input  logic [SRAM_ADDR_WIDTH-1:0] wr_addr,
   input  logic [SRAM_DATA_WIDTH-1:0] wr_data,
   output logic                       wr_ack,
   output logic                       sram_en,
   output logic                       sram_we,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
   output logic [SRAM_DATA_WIDTH-1:0] sram_wr_data,
   input  logic [SRAM_DATA_WIDTH-1:0] sram_rd_data,
   output logic                       proto_err
);
   import sram_req_responder_pkg::*;

   localparam int                TURN_W    = cnt_width(TURNAROUND);
   localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURNAROUND);
   localparam logic [TURN_W-1:0] TURN_ONE  = TURN_W'(32'd1);

   logic                       rd_pend_r, wr_pend_r;
   logic [SRAM_ADDR_WIDTH-1:0] rd_addr_r, wr_addr_r;
   logic [SRAM_DATA_WIDTH-1:0] wr_data_r;
   logic                       last_wr_r;
   logic [1:0]                 state_r;
   logic [TURN_W-1:0]          turn_cnt_r;
   logic                       proto_err_r;
   logic                       rd_ack_r, wr_ack_r, sram_en_r, sram_we_r;
   logic [SRAM_ADDR_WIDTH-1:0] sram_addr_r;
   logic [SRAM_DATA_WIDTH-1:0] sram_wr_data_r;

   logic                       rd_avail_s, wr_avail_s, wr_elig_s, tie_s, turn_active_s;
   logic [SRAM_ADDR_WIDTH-1:0] rd_addr_sel_s, wr_addr_sel_s, addr_nxt_s;
   logic [SRAM_DATA_WIDTH-1:0] wr_data_sel_s, wdata_nxt_s;
   logic [1:0]                 state_nxt_s;
   logic [TURN_W-1:0]          turn_cnt_nxt_s;

   // A request arriving this cycle is eligible immediately, so ack lands the next cycle.
   assign rd_avail_s    = rd_pend_r | rd_req;
   assign wr_avail_s    = wr_pend_r | wr_req;
   assign rd_addr_sel_s = rd_pend_r ? rd_addr_r : rd_addr;
   assign wr_addr_sel_s = wr_pend_r ? wr_addr_r : wr_addr;
   assign wr_data_sel_s = wr_pend_r ? wr_data_r : wr_data;
   assign wr_elig_s     = wr_avail_s & (turn_cnt_r == '0);
   assign tie_s         = rd_avail_s & wr_elig_s;
   assign turn_active_s = (turn_cnt_r != '0) & ((state_r == ST_READ) | (state_r == ST_TURN));

   // Arbitration: alternate on a true tie, otherwise serve whatever is eligible.
   always_comb begin
      state_nxt_s = ST_IDLE;
      if (tie_s) begin
         if (last_wr_r) begin
            state_nxt_s = ST_READ;
         end else begin
            state_nxt_s = ST_WRITE;
         end
      end else if (rd_avail_s) begin
         state_nxt_s = ST_READ;
      end else if (wr_elig_s) begin
         state_nxt_s = ST_WRITE;
      end else if (turn_active_s) begin
         state_nxt_s = ST_TURN;
      end else begin
         state_nxt_s = ST_IDLE;
      end
   end

   // Next SRAM address/data and turnaround count for the chosen operation.
   always_comb begin
      addr_nxt_s     = sram_addr_r;
      wdata_nxt_s    = sram_wr_data_r;
      turn_cnt_nxt_s = '0;
      case (state_nxt_s)
         ST_READ: begin
            addr_nxt_s     = rd_addr_sel_s;
            turn_cnt_nxt_s = TURN_LOAD;
         end
         ST_WRITE: begin
            addr_nxt_s  = wr_addr_sel_s;
            wdata_nxt_s = wr_data_sel_s;
         end
         ST_TURN: begin
            turn_cnt_nxt_s = turn_cnt_r - TURN_ONE;
         end
         default: begin
            turn_cnt_nxt_s = '0;
         end
      endcase
   end

   // Request capture, pending flags, arbitration history and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend_r      <= 1'b0;
         wr_pend_r      <= 1'b0;
         rd_addr_r      <= '0;
         wr_addr_r      <= '0;
         wr_data_r      <= '0;
         last_wr_r      <= 1'b1;
         state_r        <= ST_IDLE;
         turn_cnt_r     <= '0;
         proto_err_r    <= 1'b0;
         rd_ack_r       <= 1'b0;
         wr_ack_r       <= 1'b0;
         sram_en_r      <= 1'b0;
         sram_we_r      <= 1'b0;
         sram_addr_r    <= '0;
         sram_wr_data_r <= '0;
      end else begin
         rd_pend_r <= rd_avail_s & (state_nxt_s != ST_READ);
         wr_pend_r <= wr_avail_s & (state_nxt_s != ST_WRITE);
         if (rd_req & ~rd_pend_r) begin
            rd_addr_r <= rd_addr;
         end
         if (wr_req & ~wr_pend_r) begin
            wr_addr_r <= wr_addr;
            wr_data_r <= wr_data;
         end
         if (tie_s) begin
            last_wr_r <= (state_nxt_s == ST_WRITE);
         end
         if ((rd_req & rd_pend_r) | (wr_req & wr_pend_r)) begin
            proto_err_r <= 1'b1;
         end
         state_r        <= state_nxt_s;
         turn_cnt_r     <= turn_cnt_nxt_s;
         rd_ack_r       <= (state_nxt_s == ST_READ);
         wr_ack_r       <= (state_nxt_s == ST_WRITE);
         sram_en_r      <= (state_nxt_s == ST_READ) | (state_nxt_s == ST_WRITE);
         sram_we_r      <= (state_nxt_s == ST_WRITE);
         sram_addr_r    <= addr_nxt_s;
         sram_wr_data_r <= wdata_nxt_s;
      end
   end

   sram_rd_pipe #(
      .READ_LATENCY    (READ_LATENCY),
      .SRAM_DATA_WIDTH (SRAM_DATA_WIDTH)
   ) u_rd_pipe (
      .clk          (clk),
      .reset        (reset),
      .issue_rd     (rd_ack_r),
      .sram_rd_data (sram_rd_data),
      .rd_vld       (rd_vld),
      .rd_data      (rd_data)
   );

   assign rd_ack       = rd_ack_r;
   assign wr_ack       = wr_ack_r;
   assign sram_en      = sram_en_r;
   assign sram_we      = sram_we_r;
   assign sram_addr    = sram_addr_r;
   assign sram_wr_data = sram_wr_data_r;
   assign proto_err    = proto_err_r;

endmodule

// File: tb/tb_sram_req_responder.sv
// Bench for sram_req_responder: SRAM behavioural model, read-data scoreboard,
// a cycle table for arbitration/turnaround/protocol errors, and directed sequences.
module tb_sram_req_responder;

   localparam int SAW = 19;
   localparam int SDW = 72;
   localparam int RL  = 3;
   localparam int TA  = 1;

   localparam logic [SDW-1:0] D1 = 72'hD1_0123_4567_89AB_CDEF;
   localparam logic [SDW-1:0] D2 = 72'hD2_F0E1_D2C3_B4A5_9687;
   localparam logic [SDW-1:0] D3 = 72'hD3_1111_2222_3333_4444;
   localparam logic [SDW-1:0] D4 = 72'hD4_5555_6666_7777_8888;

   logic           clk, reset;
   logic           rd_req, wr_req;
   logic [SAW-1:0] rd_addr, wr_addr, sram_addr;
   logic [SDW-1:0] wr_data, rd_data, sram_wr_data, sram_rd_data;
   logic           rd_ack, rd_vld, wr_ack, sram_en, sram_we, proto_err;

   sram_req_responder #(
      .SRAM_ADDR_WIDTH (SAW),
      .SRAM_DATA_WIDTH (SDW),
      .READ_LATENCY    (RL),
      .TURNAROUND      (TA)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rd_req       (rd_req),
      .rd_addr      (rd_addr),
      .rd_ack       (rd_ack),
      .rd_vld       (rd_vld),
      .rd_data      (rd_data),
      .wr_req       (wr_req),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_ack       (wr_ack),
      .sram_en      (sram_en),
      .sram_we      (sram_we),
      .sram_addr    (sram_addr),
      .sram_wr_data (sram_wr_data),
      .sram_rd_data (sram_rd_data),
      .proto_err    (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Initial SRAM contents: address-derived, except 0x10 which holds 0xAB.
   function automatic logic [SDW-1:0] pattern(input logic [SAW-1:0] a);
      logic [SDW-1:0] v;
      if (a == 19'h00010) v = 72'hAB;
      else                v = {a, 8'h5C, 26'd0, a};
      return v;
   endfunction

   // SRAM model: write on issue, read data appears RL cycles after issue.
   logic [SDW-1:0] mem_m   [0:(1<<SAW)-1];
   bit             wflag_m [0:(1<<SAW)-1];
   logic [SDW-1:0] rd_pipe_m [0:RL-1];
   always @(posedge clk) begin
      if (sram_en && sram_we) begin
         mem_m[sram_addr]   <= sram_wr_data;
         wflag_m[sram_addr] <= 1'b1;
      end
      if (sram_en && !sram_we)
         rd_pipe_m[0] <= wflag_m[sram_addr] ? mem_m[sram_addr] : pattern(sram_addr);
      else
         rd_pipe_m[0] <= 72'hEE_EEEE_EEEE_EEEE_EEEE;
      for (int k = 1; k < RL; k++) rd_pipe_m[k] <= rd_pipe_m[k-1];
   end
   assign sram_rd_data = rd_pipe_m[RL-1];

   // Reference contents as seen by the requester, updated when writes are requested.
   logic [SDW-1:0] ref_mem [logic [SAW-1:0]];
   function automatic logic [SDW-1:0] exp_read(input logic [SAW-1:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      else                   return pattern(a);
   endfunction

   typedef struct {
      logic           rq;
      logic [SAW-1:0] ra;
      logic           wq;
      logic [SAW-1:0] wa;
      logic [SDW-1:0] wd;
      logic           push;
      logic [4:0]     flags;   // {rd_ack, wr_ack, sram_en, sram_we, proto_err}
      logic [SAW-1:0] ea;
      logic [SDW-1:0] ew;
   } vec_t;

   function automatic vec_t mk(input logic rq, input logic [SAW-1:0] ra, input logic wq,
                               input logic [SAW-1:0] wa, input logic [SDW-1:0] wd,
                               input logic push, input logic [4:0] flags,
                               input logic [SAW-1:0] ea, input logic [SDW-1:0] ew);
      vec_t v;
      v.rq = rq; v.ra = ra; v.wq = wq; v.wa = wa; v.wd = wd;
      v.push = push; v.flags = flags; v.ea = ea; v.ew = ew;
      return v;
   endfunction

   int             n_checks = 0;
   int             n_errs   = 0;
   int             n_vld    = 0;
   int             vld_run  = 0;
   int             max_run  = 0;
   logic [SDW-1:0] exp_q [$];
   logic [SDW-1:0] exp_d;
   vec_t           vecs [0:15];

   task automatic chk(input string name, input logic [SDW-1:0] act, input logic [SDW-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_errs++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Advance one cycle, then sample outputs and service the read scoreboard.
   task automatic tick();
      @(posedge clk);
      #1;
      if (rd_vld) begin
         n_vld++;
         vld_run++;
         if (vld_run > max_run) max_run = vld_run;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errs++;
            $display("FAIL sb_unexpected_rd_vld: got rd_vld=1 data=%h, required no rd_vld", rd_data);
         end else begin
            exp_d = exp_q.pop_front();
            chk("sb_rd_data", rd_data, exp_d);
         end
      end else begin
         vld_run = 0;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_flags"}, 72'({rd_ack, wr_ack, sram_en, sram_we, proto_err, rd_vld}), 72'd0);
      chk({tag, "_sram_addr"}, 72'(sram_addr), 72'd0);
      chk({tag, "_sram_wr_data"}, sram_wr_data, 72'd0);
      chk({tag, "_rd_data"}, rd_data, 72'd0);
   endtask

   initial begin
      int lat;
      int n0;
      bit found;

      vecs[0]  = mk(1'b1, 19'h100, 1'b1, 19'h200, D1, 1'b1, 5'b10100, 19'h100, 72'd0);
      vecs[1]  = mk(1'b0, 19'h0,   1'b0, 19'h0,   72'd0, 1'b0, 5'b00000, 19'h0, 72'd0);
      vecs[2]  = mk(1'b0, 19'h0,   1'b0, 19'h0,   72'd0, 1'b0, 5'b01110, 19'h200, D1);
      vecs[3]  = mk(1'b0, 19'h0,   1'b0, 19'h0,   72'd0, 1'b0, 5'b00000, 19'h0, 72'd0);
      vecs[4]  = mk(1'b1, 19'h101, 1'b1, 19'h201, D2, 1'b1, 5'b01110, 19'h201, D2);
      vecs[5]  = mk(1'b0, 19'h0,   1'b0, 19'h0,   72'd0, 1'b0, 5'b10100, 19'h101, 72'd0);
      vecs[6]  = mk(1'b0, 19'h0,   1'b0, 19'h0,   72'd0, 1'b0, 5'b00000, 19'h0, 72'd0);
      vecs[7]  = mk(1'b0, 19'h0,   1'b0, 19'h0,   72'd0, 1'b0, 5'b00000, 19'h0, 72'd0);
      vecs[8]  = mk(1'b1, 19'h102, 1'b1, 19'h202, D3, 1'b1, 5'b10100, 19'h102, 72'd0);
      vecs[9]  = mk(1'b0, 19'h0,   1'b0, 19'h0,   72'd0, 1'b0, 5'b00000, 19'h0, 72'd0);
      vecs[10] = mk(1'b0, 19'h0,   1'b0, 19'h0,   72'd0, 1'b0, 5'b01110, 19'h202, D3);
      vecs[11] = mk(1'b0, 19'h0,   1'b0, 19'h0,   72'd0, 1'b0, 5'b00000, 19'h0, 72'd0);
      vecs[12] = mk(1'b1, 19'h103, 1'b1, 19'h203, D4, 1'b1, 5'b01110, 19'h203, D4);
      vecs[13] = mk(1'b1, 19'h1FF, 1'b0, 19'h0,   72'd0, 1'b0, 5'b10101, 19'h103, 72'd0);
      vecs[14] = mk(1'b0, 19'h0,   1'b0, 19'h0,   72'd0, 1'b0, 5'b00001, 19'h0, 72'd0);
      vecs[15] = mk(1'b0, 19'h0,   1'b0, 19'h0,   72'd0, 1'b0, 5'b00001, 19'h0, 72'd0);

      reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
      rd_addr = '0; wr_addr = '0; wr_data = '0;
      repeat (3) tick();
      chk_all_zero("reset");
      reset = 1'b0;
      repeat (2) tick();

      // Single read: ack next cycle, data four cycles after the ack.
      rd_req = 1'b1; rd_addr = 19'h00010; exp_q.push_back(exp_read(19'h00010));
      tick();
      rd_req = 1'b0;
      chk("t1_flags", 72'({rd_ack, wr_ack, sram_en, sram_we}), 72'b1010);
      chk("t1_addr", 72'(sram_addr), 72'h10);
      lat = 0; found = 1'b0;
      for (int k = 1; k <= 10 && !found; k++) begin
         tick();
         if (rd_vld) begin found = 1'b1; lat = k; end
      end
      chk("t1_latency", 72'(lat), 72'd4);
      chk("t1_data", rd_data, 72'hAB);
      repeat (3) tick();

      // Write at the top of the address range, then read it back.
      wr_req = 1'b1; wr_addr = 19'h7FFFE; wr_data = 72'h5A5A; ref_mem[19'h7FFFE] = 72'h5A5A;
      tick();
      wr_req = 1'b0;
      chk("t2_flags", 72'({rd_ack, wr_ack, sram_en, sram_we}), 72'b0111);
      chk("t2_addr", 72'(sram_addr), 72'h7FFFE);
      chk("t2_wdata", sram_wr_data, 72'h5A5A);
      rd_req = 1'b1; rd_addr = 19'h7FFFE; exp_q.push_back(exp_read(19'h7FFFE));
      tick();
      rd_req = 1'b0;
      chk("t2_rd_flags", 72'({rd_ack, wr_ack, sram_en, sram_we}), 72'b1010);
      chk("t2_rd_addr", 72'(sram_addr), 72'h7FFFE);
      repeat (8) tick();

      // Back-to-back reads, one per cycle.
      max_run = 0; vld_run = 0;
      for (int i = 0; i < 8; i++) begin
         rd_req = 1'b1; rd_addr = 19'(i); exp_q.push_back(exp_read(19'(i)));
         tick();
         chk($sformatf("t4_ack%0d", i), 72'({rd_ack, sram_en, sram_we}), 72'b110);
         chk($sformatf("t4_addr%0d", i), 72'(sram_addr), 72'(i));
      end
      rd_req = 1'b0;
      repeat (10) tick();
      chk("t4_vld_run", 72'(max_run), 72'd8);

      // Cycle table: ties, alternation, turnaround, ignored duplicate read.
      for (int i = 0; i < 16; i++) begin
         rd_req = vecs[i].rq; rd_addr = vecs[i].ra;
         wr_req = vecs[i].wq; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
         if (vecs[i].push) exp_q.push_back(exp_read(vecs[i].ra));
         if (vecs[i].wq) ref_mem[vecs[i].wa] = vecs[i].wd;
         tick();
         chk($sformatf("vec%0d_flags", i),
             72'({rd_ack, wr_ack, sram_en, sram_we, proto_err}), 72'(vecs[i].flags));
         if (vecs[i].flags[2]) chk($sformatf("vec%0d_addr", i), 72'(sram_addr), 72'(vecs[i].ea));
         if (vecs[i].flags[1]) chk($sformatf("vec%0d_wdata", i), sram_wr_data, vecs[i].ew);
      end
      rd_req = 1'b0; wr_req = 1'b0;
      repeat (8) tick();
      chk("proto_sticky", 72'(proto_err), 72'd1);

      // Reset one cycle after a read ack: the read must never return.
      rd_req = 1'b1; rd_addr = 19'h00005;
      tick();
      rd_req = 1'b0;
      chk("t6_ack", 72'(rd_ack), 72'd1);
      tick();
      reset = 1'b1;
      tick();
      chk_all_zero("t6_reset");
      reset = 1'b0;
      n0 = n_vld;
      repeat (10) tick();
      chk("t6_no_vld", 72'(n_vld - n0), 72'd0);

      chk("sb_drained", 72'(exp_q.size()), 72'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end

endmodule
